instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage of the single-issue RV32I core: holds the PC, requests instructions from imem, and presents
//  each word (instr, pc) to decode/Main_controller via valid/ready. At the retire handshake it resolves the
//  next PC from the decoded branch/jump strobes and execute flags, then starts the next fetch.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  XLEN       32             datapath width; only 32 supported
// PORTS
//  clk          in   1     single clock, rising edge
//  rst          in   1     asynchronous, active-high reset
//  imem_req     out  1     one-cycle fetch request pulse
//  imem_addr    out  XLEN  fetch address, equals pc, stable from req until rvalid
//  imem_rvalid  in   1     read data valid, >=1 cycle after imem_req
//  imem_rdata   in   32    instruction word
//  instr        out  32    held instruction for decode
//  pc           out  XLEN  address of instr
//  pc_plus4     out  XLEN  pc+4, link value for jal/jalr
//  instr_valid  out  1     instr/pc valid
//  instr_ready  in   1     core retires instr this cycle; decode strobes below valid
//  beq,bne,blt,bge,bltu,bgeu,jal,jalr  in 1 each  decoded strobes from Main_controller
//  alu_zero     in   1     rs1==rs2 (sub result zero)
//  alu_lt       in   1     rs1<rs2 signed
//  alu_ltu      in   1     rs1<rs2 unsigned
//  imm          in   XLEN  sign-extended B/J/I immediate
//  rs1_val      in   XLEN  rs1 operand for jalr
//  fetch_err    out  1     sticky: misaligned next PC; fetch halted
// BEHAVIOUR
//  - Reset values: pc=RESET_PC, instr=32'h0000_0013 (nop), instr_valid=0, imem_req=0, fetch_err=0, state=IDLE.
//  - FSM IDLE->REQ->WAIT->VALID->REQ..., plus HALT:
//    IDLE : one cycle after reset release; -> REQ.
//    REQ  : imem_req=1, imem_addr=pc; -> WAIT.
//    WAIT : on imem_rvalid capture imem_rdata into instr; -> VALID. Otherwise hold.
//    VALID: instr_valid=1; hold instr/pc while !instr_ready. On instr_ready: pc<=next_pc; -> REQ,
//           or -> HALT if next_pc[1:0]!=0 (fetch_err<=1, pc unchanged).
//    HALT : no requests, instr_valid=0; left only by rst.
//  - Latency: 1-cycle imem gives instr_valid 2 cycles after imem_req; throughput 1 instr per 3 cycles min.
//  - next_pc (combinational, used only at VALID & instr_ready):
//    jal  -> pc+imm;  jalr -> (rs1_val+imm) & ~32'h1;
//    taken branch -> pc+imm: beq=alu_zero, bne=!alu_zero, blt=alu_lt, bge=!alu_lt, bltu=alu_ltu, bgeu=!alu_ltu;
//    otherwise pc+4. Priority jal > jalr > branch > sequential (strobes one-hot; priority defines X-case).
//  - All adds modulo 2^32: pc 32'hFFFF_FFFC + 4 wraps to 0, no flag. Misalignment check only bit 1
//    (jalr bit 0 already cleared; branch/jal imm is even).
//  - imem_rvalid outside WAIT ignored. instr_ready outside VALID ignored; strobes ignored outside retire.
//  - rst mid-operation (any state incl. WAIT): immediate return to reset values; imem shares rst, so no
//    stale rvalid arrives after reset.
//  - pc_plus4 = pc+4 combinationally, valid whenever instr_valid.
// STRUCTURE
//  - Fetch state encodings and nop constant go in shared parameters.v alongside the opcode defines.
//  - Sub-module next_pc_gen: purely combinational branch resolution + target adders; FSM/registers stay here.
// TESTING
//  - Reset, RESET_PC=0, 1-cycle imem, instr_ready=1, no strobes: imem_addr sequence 0,4,8; instr_valid
//    3 cycles apart.
//  - beq, alu_zero=1, pc=0x10, imm=-8: next imem_addr=0x08; same with alu_zero=0: 0x14.
//  - bgeu alu_ltu=0 -> taken; blt alu_lt=0 -> not taken; jal pc=0x20 imm=0x100 -> 0x120, pc_plus4=0x24.
//  - jalr rs1=0x1001 imm=2 -> 0x1002 -> fetch_err=1, no further imem_req until rst.
//  - instr_ready low 5 cycles in VALID: instr/pc stable, no imem_req; imem latency 4: instr_valid waits.
//  - rst asserted during WAIT: outputs to reset values same cycle; pc=FFFF_FFFC sequential -> 0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared fetch-stage constants, FSM encodings and branch-strobe types
package instr_fetch_unit_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_VALID = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic beq;
    logic bne;
    logic blt;
    logic bge;
    logic bltu;
    logic bgeu;
    logic jal;
    logic jalr;
  } br_strobe_t;

  typedef struct packed {
    logic zero;
    logic lt;
    logic ltu;
  } alu_flags_t;

  function automatic logic branch_taken(input br_strobe_t s, input alu_flags_t f);
    return (s.beq  &&  f.zero) || (s.bne  && !f.zero) ||
           (s.blt  &&  f.lt)   || (s.bge  && !f.lt)   ||
           (s.bltu &&  f.ltu)  || (s.bgeu && !f.ltu);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_gen.sv
// rtl/instr_fetch_unit_next_pc_gen.sv - combinational branch resolution and next-PC target selection
module instr_fetch_unit_next_pc_gen
  import instr_fetch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  br_strobe_t      strb,
  input  alu_flags_t      flags,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] jalr_sum;

  // All adds wrap modulo 2^XLEN; jalr drops bit 0 of its target.
  always_comb begin
    pc_plus4   = pc + XLEN'(4);
    rel_target = pc + imm;
    jalr_sum   = rs1_val + imm;
    next_pc    = pc_plus4;
    if (strb.jal) begin
      next_pc = rel_target;
    end else if (strb.jalr) begin
      next_pc = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (branch_taken(strb, flags)) begin
      next_pc = rel_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV32I fetch stage: PC register, imem request FSM, retire-time next-PC update
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            beq,
  input  logic            bne,
  input  logic            blt,
  input  logic            bge,
  input  logic            bltu,
  input  logic            bgeu,
  input  logic            jal,
  input  logic            jalr,
  input  logic            alu_zero,
  input  logic            alu_lt,
  input  logic            alu_ltu,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  output logic            fetch_err
);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            fetch_err_q, fetch_err_d;
  logic [XLEN-1:0] next_pc;
  br_strobe_t      strb;
  alu_flags_t      flags;

  assign strb  = '{beq: beq, bne: bne, blt: blt, bge: bge, bltu: bltu, bgeu: bgeu, jal: jal, jalr: jalr};
  assign flags = '{zero: alu_zero, lt: alu_lt, ltu: alu_ltu};

  instr_fetch_unit_next_pc_gen #(.XLEN(XLEN)) u_next_pc_gen (
    .pc       (pc_q),
    .imm      (imm),
    .rs1_val  (rs1_val),
    .strb     (strb),
    .flags    (flags),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    fetch_err_d = fetch_err_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        // A misaligned target parks the stage with pc left on the offending instruction.
        if (instr_ready) begin
          if (next_pc[1:0] != 2'b00) begin
            fetch_err_d = 1'b1;
            state_d     = ST_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = ST_REQ;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC[XLEN-1:0];
      instr_q     <= NOP_INSTR;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign instr_valid = (state_q == ST_VALID);
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed-vector bench for instr_fetch_unit with a variable-latency imem model
module tb_instr_fetch_unit;

  localparam logic [7:0] S_NONE = 8'h00;
  localparam logic [7:0] S_BEQ  = 8'h80;
  localparam logic [7:0] S_BLT  = 8'h20;
  localparam logic [7:0] S_BLTU = 8'h08;
  localparam logic [7:0] S_BGEU = 8'h04;
  localparam logic [7:0] S_JAL  = 8'h02;
  localparam logic [7:0] S_JALR = 8'h01;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        beq = 0, bne = 0, blt = 0, bge = 0, bltu = 0, bgeu = 0, jal = 0, jalr = 0;
  logic        alu_zero = 0, alu_lt = 0, alu_ltu = 0;
  logic [31:0] imm = '0;
  logic [31:0] rs1_val = '0;
  logic        fetch_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int mem_lat = 1;
  int t_req, t_valid, t_prev_valid;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .beq(beq), .bne(bne), .blt(blt), .bge(bge), .bltu(bltu), .bgeu(bgeu), .jal(jal), .jalr(jalr),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .imm(imm), .rs1_val(rs1_val), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // imem: request seen at a negedge, rvalid raised mem_lat negedges later for one cycle
  initial begin
    logic [31:0] a;
    logic abort;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (imem_req && !rst) begin
        a = imem_addr;
        abort = 1'b0;
        for (int i = 0; i < mem_lat; i++) begin
          @(negedge clk);
          if (rst) begin
            abort = 1'b1;
            break;
          end
        end
        if (!abort) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(a);
          @(negedge clk);
          imem_rvalid = 1'b0;
        end
      end
    end
  end

  task automatic wait_for_req(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!imem_req && n < 40);
    if (!imem_req) check({tag, "_req_timeout"}, 32'd0, 32'd1);
    t_req = cyc;
  endtask

  task automatic wait_for_valid(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 40);
    if (!instr_valid) check({tag, "_valid_timeout"}, 32'd0, 32'd1);
    t_valid = cyc;
  endtask

  task automatic retire(input logic [7:0] s, input logic z, input logic lt, input logic ltu,
                        input logic [31:0] imm_v, input logic [31:0] rs1_v);
    {beq, bne, blt, bge, bltu, bgeu, jal, jalr} = s;
    {alu_zero, alu_lt, alu_ltu} = {z, lt, ltu};
    imm = imm_v;
    rs1_val = rs1_v;
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    {beq, bne, blt, bge, bltu, bgeu, jal, jalr} = S_NONE;
    {alu_zero, alu_lt, alu_ltu} = 3'b000;
    imm = '0;
    rs1_val = '0;
    instr_ready = 1'b0;
  endtask

  task automatic do_retire(input string tag, input logic [7:0] s, input logic z, input logic lt,
                           input logic ltu, input logic [31:0] imm_v, input logic [31:0] rs1_v,
                           input logic [31:0] exp_pc);
    retire(s, z, lt, ltu, imm_v, rs1_v);
    wait_for_req(tag);
    check({tag, "_addr"}, imem_addr, exp_pc);
    wait_for_valid(tag);
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_instr"}, instr, mem_word(exp_pc));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    check("rst_pc_plus4", pc_plus4, 32'h4);

    // sequential streaming with instr_ready tied high
    instr_ready = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_for_req("seq");
      check("seq_addr", imem_addr, 32'(4 * k));
      if (k == 0) check("seq_first_req_cycles", 32'(t_req), 32'(cyc));
      wait_for_valid("seq");
      check("seq_req_to_valid", 32'(t_valid - t_req), 32'd2);
      check("seq_pc", pc, 32'(4 * k));
      check("seq_instr", instr, mem_word(32'(4 * k)));
      if (k > 0) check("seq_spacing", 32'(t_valid - t_prev_valid), 32'd3);
      t_prev_valid = t_valid;
    end
    instr_ready = 1'b0;

    // stall in VALID: nothing moves, no requests
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_pc", pc, 32'h8);
      check("hold_instr", instr, mem_word(32'h8));
      check("hold_req", {31'd0, imem_req}, 32'd0);
    end

    do_retire("seq_c",     S_NONE, 0, 0, 0, 32'h0, 32'h0, 32'h0C);
    do_retire("seq_10",    S_NONE, 0, 0, 0, 32'h0, 32'h0, 32'h10);
    do_retire("beq_taken", S_BEQ,  1, 0, 0, 32'hFFFF_FFF8, 32'h0, 32'h08);
    do_retire("jal_back",  S_JAL,  0, 0, 0, 32'h8, 32'h0, 32'h10);
    do_retire("beq_nt",    S_BEQ,  0, 0, 0, 32'hFFFF_FFF8, 32'h0, 32'h14);
    do_retire("blt_nt",    S_BLT,  0, 0, 0, 32'h40, 32'h0, 32'h18);
    do_retire("bgeu_tk",   S_BGEU, 0, 0, 0, 32'h8, 32'h0, 32'h20);
    check("jal_pc_plus4", pc_plus4, 32'h24);
    do_retire("jal_fwd",   S_JAL,  0, 0, 0, 32'h100, 32'h0, 32'h120);
    do_retire("bltu_tk",   S_BLTU, 0, 0, 1, 32'h10, 32'h0, 32'h130);

    // 4-cycle imem
    mem_lat = 4;
    retire(S_NONE, 0, 0, 0, 32'h0, 32'h0);
    wait_for_req("lat4");
    check("lat4_addr", imem_addr, 32'h134);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lat4_not_valid", {31'd0, instr_valid}, 32'd0);
    end
    @(negedge clk);
    check("lat4_valid", {31'd0, instr_valid}, 32'd1);
    check("lat4_pc", pc, 32'h134);
    mem_lat = 1;

    // misaligned jalr target halts fetch
    retire(S_JALR, 0, 0, 0, 32'h2, 32'h1001);
    @(negedge clk);
    check("halt_err", {31'd0, fetch_err}, 32'd1);
    check("halt_valid", {31'd0, instr_valid}, 32'd0);
    check("halt_pc", pc, 32'h134);
    begin
      int reqs = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (imem_req) reqs++;
      end
      check("halt_no_req", 32'(reqs), 32'd0);
    end
    check("halt_err_sticky", {31'd0, fetch_err}, 32'd1);

    // reset clears the halt, then reset again while WAIT is pending
    rst = 1'b1;
    mem_lat = 4;
    repeat (2) @(negedge clk);
    check("rst2_err", {31'd0, fetch_err}, 32'd0);
    rst = 1'b0;
    wait_for_req("rstw");
    check("rstw_addr", imem_addr, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstw_req", {31'd0, imem_req}, 32'd0);
    check("rstw_valid", {31'd0, instr_valid}, 32'd0);
    check("rstw_pc", pc, 32'h0);
    check("rstw_instr", instr, 32'h0000_0013);
    repeat (2) @(negedge clk);
    mem_lat = 1;
    rst = 1'b0;
    wait_for_req("post_rst");
    check("post_rst_addr", imem_addr, 32'h0);
    wait_for_valid("post_rst");
    check("post_rst_instr", instr, mem_word(32'h0));

    // wrap at top of address space
    do_retire("jalr_top", S_JALR, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    do_retire("wrap_seq", S_NONE, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    check("wrap_err", {31'd0, fetch_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
